imem_port_arbiter: RTL and testbench
====================================

# imem_port_arbiter

Two-requester arbiter that shares one asynchronous-read instruction memory port between two fetch requesters, such as the two fetch streams of the MIPS32 core. Grants at most one request per cycle with round-robin fairness and drives the granted address to the memory. It registers the returned word back to the winner with a one-cycle valid pulse. It also keeps saturating per-port stall counters for performance debug.

## Interface
- AW, 6, instruction memory word-address width
- DW, 32, instruction word width
- CW, 16, stall counter width
- CLK  in  1  system clock, rising edge
- RST  in  1  reset, asynchronous, active-high
- req0  in  1  port 0 request; held with addr0 stable until gnt0
- addr0  in  AW  port 0 word address
- gnt0  out  1  port 0 granted this cycle (combinational)
- rvalid0  out  1  rdata0 valid, one-cycle pulse
- rdata0  out  DW  port 0 returned instruction word
- req1, addr1, gnt1, rvalid1, rdata1: same as port 0, for port 1
- mem_a  out  AW  address to instruction memory
- mem_rd  in  DW  memory read data; asynchronous, valid same cycle as mem_a
- stall0, stall1  out  CW  cycles the port requested but was not granted

## Operation
- State: last-grant pointer `lg` (1 bit), response registers per port, stall counters.
- Grant rule, evaluated every cycle while RST low:
  - Only req0 high: gnt0=1.
  - Only req1 high: gnt1=1.
  - Both high: grant the port ≠ `lg`.
  - Neither high: no grant.
- gnt0 and gnt1 are never both high.
- On a grant, `lg` ← granted port index at the clock edge. With no grant, `lg` holds.
- mem_a = addr of the granted port. With no grant, mem_a = 0.
- Response capture: at the edge ending a granted cycle, rdataX ← mem_rd and rvalidX ← 1 for the granted port; the other port's rvalid ← 0.
- rdataX holds its value until the next grant to port X.
- Stall counters: stallX increments at each edge where reqX=1 and gntX=0, and saturates at 2^CW−1 (no wrap).
- The arbiter does not track outstanding requests. A requester may re-request in the cycle its gnt is high, i.e. keep req high with a new address the next cycle.
- Reset values:
  - gnt0/gnt1=0, forced low while RST high.
  - rvalid0/1=0, rdata0/1=0, mem_a=0, stall0/1=0.
  - `lg`=1, so port 0 wins the first contended cycle.
- Reset mid-operation: all state clears immediately and asynchronously. A grant in progress is dropped and no rvalid follows it. The first cycle after RST falls behaves as post-reset.

## Timing
- Grant latency: 0 cycles (gnt is combinational from req and `lg`).
- Data latency: request granted in cycle N → rvalid high and rdata valid throughout cycle N+1, exactly one cycle.
- Throughput: one access per cycle total. Under continuous dual request each port is granted every other cycle and gets one rvalid every other cycle.
- Single requester holding req continuously: granted every cycle, rvalid high every cycle from N+1.
- Contention: a losing port keeps req and addr stable. It is guaranteed a grant in the next cycle (max wait 1 cycle).
- Stall counter update is visible the cycle after the stalled cycle.

## Structure
- Shared package `imem_pkg` holds:
  - default AW/DW/CW constants;
  - port index constants PORT0=0, PORT1=1;
  - the stall counter saturation value.
- One natural sub-module, `rr_arb2`: a 2-way round-robin arbiter containing `lg`, with inputs req[1:0], CLK, RST and output gnt[1:0] (one-hot or zero).
- The top level adds the address mux, response registers and stall counters.

## Test plan
- Reset: hold RST high with req0=req1=1 → gnt0=gnt1=0, rvalids 0, stalls 0, mem_a=0. Assert RST asynchronously mid-cycle after a grant → rvalid0 stays 0 the next cycle.
- Single port: req0=1, addr0=5 for 3 cycles with mem[5]=0x2402000A → gnt0=1 for all 3 cycles, rvalid0=1 from the next cycle for 3 cycles, rdata0=0x2402000A, stall0=0.
- Contention: req0=req1=1 from reset, addr0=3, addr1=7, held for 4 cycles → grant order 0,1,0,1; mem_a=3,7,3,7; rvalid0 and rvalid1 alternate one cycle later; stall0=2, stall1=2.
- Pointer memory: grant port 1 alone, then req0=req1 together → port 0 wins.
- Saturation: with CW forced to 4, hold req1 while port 0 requests continuously… use req0 and req1 high with port 1 repeatedly losing via forced `lg` → stall1 stops at 15, no wrap to 0.
- Idle: no requests for 5 cycles → mem_a=0, rvalids 0, rdata0/1 keep their last values, stalls unchanged.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory port arbiter.
// Contents:
//   - default address, data and stall-counter widths
//   - port index encoding (PORT0 / PORT1)
//   - saturation value of a default-width stall counter
package imem_pkg;

  localparam int unsigned AW_DEF = 6;
  localparam int unsigned DW_DEF = 32;
  localparam int unsigned CW_DEF = 16;

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_e;

  localparam logic [CW_DEF-1:0] STALL_SAT_DEF = {CW_DEF{1'b1}};

endpackage

// File: rtl/imem_port_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter.
// Ports:
//   clk_i  - clock, rising edge
//   rst_i  - asynchronous active-high reset
//   req_i  - request vector, bit n = port n
//   gnt_o  - grant vector, one-hot or zero, combinational from req_i
//            and the last-grant pointer
// The last-grant pointer resets to PORT1 so port 0 wins the first
// contended cycle.
module rr_arb2
  import imem_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  port_e lg_q, lg_d;

  always_comb begin
    gnt_o = 2'b00;
    lg_d  = lg_q;
    // Grants are suppressed while reset is held so nothing is captured
    // at an edge that lands inside the reset window.
    if (!rst_i) begin
      unique case (req_i)
        2'b01:   gnt_o = 2'b01;
        2'b10:   gnt_o = 2'b10;
        2'b11:   gnt_o = (lg_q == PORT1) ? 2'b01 : 2'b10;
        default: gnt_o = 2'b00;
      endcase
    end
    if (gnt_o[0]) begin
      lg_d = PORT0;
    end else if (gnt_o[1]) begin
      lg_d = PORT1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lg_q <= PORT1;
    end else begin
      lg_q <= lg_d;
    end
  end

endmodule

// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter: shares one asynchronous-read instruction memory port
// between two fetch requesters.
// Ports:
//   clk_i, rst_i           - clock (rising edge), async active-high reset
//   req0_i/addr0_i         - port 0 request and word address
//   gnt0_o                 - port 0 granted this cycle (combinational)
//   rvalid0_o/rdata0_o     - port 0 response, one cycle after the grant
//   req1_i .. rdata1_o     - same for port 1
//   mem_a_o                - address to memory (0 when idle)
//   mem_rd_i               - memory read data, valid in the same cycle
//   stall0_o, stall1_o     - saturating count of requested-but-not-granted
//                            cycles per port
module imem_port_arbiter
  import imem_pkg::*;
#(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned DW = DW_DEF,
  parameter int unsigned CW = CW_DEF
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          req0_i,
  input  logic [AW-1:0] addr0_i,
  output logic          gnt0_o,
  output logic          rvalid0_o,
  output logic [DW-1:0] rdata0_o,
  input  logic          req1_i,
  input  logic [AW-1:0] addr1_i,
  output logic          gnt1_o,
  output logic          rvalid1_o,
  output logic [DW-1:0] rdata1_o,
  output logic [AW-1:0] mem_a_o,
  input  logic [DW-1:0] mem_rd_i,
  output logic [CW-1:0] stall0_o,
  output logic [CW-1:0] stall1_o
);

  localparam logic [CW-1:0] STALL_SAT = {CW{1'b1}};
  localparam logic [CW-1:0] STALL_ONE = {{(CW-1){1'b0}}, 1'b1};

  logic [1:0]    gnt;
  logic          rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic [DW-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic [CW-1:0] stall0_q, stall0_d, stall1_q, stall1_d;

  rr_arb2 u_rr_arb2 (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .req_i ({req1_i, req0_i}),
    .gnt_o (gnt)
  );

  assign gnt0_o = gnt[PORT0];
  assign gnt1_o = gnt[PORT1];

  always_comb begin
    mem_a_o = '0;
    if (gnt[PORT0]) begin
      mem_a_o = addr0_i;
    end else if (gnt[PORT1]) begin
      mem_a_o = addr1_i;
    end
  end

  always_comb begin
    rvalid0_d = gnt[PORT0];
    rvalid1_d = gnt[PORT1];
    rdata0_d  = gnt[PORT0] ? mem_rd_i : rdata0_q;
    rdata1_d  = gnt[PORT1] ? mem_rd_i : rdata1_q;
    stall0_d  = stall0_q;
    stall1_d  = stall1_q;
    if (req0_i && !gnt[PORT0] && (stall0_q != STALL_SAT)) begin
      stall0_d = stall0_q + STALL_ONE;
    end
    if (req1_i && !gnt[PORT1] && (stall1_q != STALL_SAT)) begin
      stall1_d = stall1_q + STALL_ONE;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
      stall0_q  <= '0;
      stall1_q  <= '0;
    end else begin
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
      stall0_q  <= stall0_d;
      stall1_q  <= stall1_d;
    end
  end

  assign rvalid0_o = rvalid0_q;
  assign rvalid1_o = rvalid1_q;
  assign rdata0_o  = rdata0_q;
  assign rdata1_o  = rdata1_q;
  assign stall0_o  = stall0_q;
  assign stall1_o  = stall1_q;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed bench for imem_port_arbiter. A second instance with a 4-bit
// stall counter shares the stimulus to exercise counter saturation.
module tb_imem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1;
  logic [5:0]  addr0, addr1;
  logic        gnt0, gnt1, rvalid0, rvalid1;
  logic [31:0] rdata0, rdata1, mem_rd;
  logic [5:0]  mem_a;
  logic [15:0] stall0, stall1;

  logic        gnt0_4, gnt1_4, rvalid0_4, rvalid1_4;
  logic [31:0] rdata0_4, rdata1_4, mem_rd_4;
  logic [5:0]  mem_a_4;
  logic [3:0]  stall0_4, stall1_4;

  logic [31:0] mem [64];

  always #5 clk = ~clk;

  assign mem_rd   = mem[mem_a];
  assign mem_rd_4 = mem[mem_a_4];

  imem_port_arbiter #(.AW(6), .DW(32), .CW(16)) dut (
    .clk_i(clk), .rst_i(rst),
    .req0_i(req0), .addr0_i(addr0), .gnt0_o(gnt0), .rvalid0_o(rvalid0), .rdata0_o(rdata0),
    .req1_i(req1), .addr1_i(addr1), .gnt1_o(gnt1), .rvalid1_o(rvalid1), .rdata1_o(rdata1),
    .mem_a_o(mem_a), .mem_rd_i(mem_rd), .stall0_o(stall0), .stall1_o(stall1)
  );

  imem_port_arbiter #(.AW(6), .DW(32), .CW(4)) dut4 (
    .clk_i(clk), .rst_i(rst),
    .req0_i(req0), .addr0_i(addr0), .gnt0_o(gnt0_4), .rvalid0_o(rvalid0_4), .rdata0_o(rdata0_4),
    .req1_i(req1), .addr1_i(addr1), .gnt1_o(gnt1_4), .rvalid1_o(rvalid1_4), .rdata1_o(rdata1_4),
    .mem_a_o(mem_a_4), .mem_rd_i(mem_rd_4), .stall0_o(stall0_4), .stall1_o(stall1_4)
  );

  typedef struct packed {
    logic        port;
    logic [31:0] data;
  } resp_t;

  resp_t       sb[$];
  int          checks = 0;
  int          errors = 0;
  logic        m_lg;
  int          m_st0, m_st1, m_st4_0, m_st4_1;
  logic [31:0] m_rd0, m_rd1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_lg = 1'b1;
    m_st0 = 0; m_st1 = 0; m_st4_0 = 0; m_st4_1 = 0;
    m_rd0 = '0; m_rd1 = '0;
    sb.delete();
  endtask

  // One clock cycle: inputs are already driven. Grant/address checked at
  // the falling edge, registered outputs checked 1 time unit after the rise.
  task automatic cycle();
    logic        eg0, eg1;
    logic [5:0]  ea;
    logic [31:0] ed;
    resp_t       r;
    @(negedge clk);
    eg0 = 1'b0;
    eg1 = 1'b0;
    if (!rst) begin
      eg0 = req0 && (!req1 || m_lg == 1'b1);
      eg1 = req1 && (!req0 || m_lg == 1'b0);
    end
    ea = eg0 ? addr0 : (eg1 ? addr1 : 6'd0);
    ed = mem[ea];
    chk("gnt0", gnt0, eg0);
    chk("gnt1", gnt1, eg1);
    chk("mem_a", mem_a, ea);
    chk("gnt0_cw4", gnt0_4, eg0);
    @(posedge clk);
    #1;
    if (!rst) begin
      if (eg0) begin m_lg = 1'b0; sb.push_back('{1'b0, ed}); end
      if (eg1) begin m_lg = 1'b1; sb.push_back('{1'b1, ed}); end
      if (req0 && !eg0) begin
        if (m_st0 < 65535) m_st0++;
        if (m_st4_0 < 15) m_st4_0++;
      end
      if (req1 && !eg1) begin
        if (m_st1 < 65535) m_st1++;
        if (m_st4_1 < 15) m_st4_1++;
      end
    end
    if (sb.size() > 0) begin
      r = sb.pop_front();
      if (r.port) m_rd1 = r.data; else m_rd0 = r.data;
      chk("rvalid0", rvalid0, !r.port);
      chk("rvalid1", rvalid1, r.port);
    end else begin
      chk("rvalid0_idle", rvalid0, 1'b0);
      chk("rvalid1_idle", rvalid1, 1'b0);
    end
    chk("rdata0", rdata0, m_rd0);
    chk("rdata1", rdata1, m_rd1);
    chk("stall0", stall0, m_st0);
    chk("stall1", stall1, m_st1);
    chk("stall0_cw4", stall0_4, m_st4_0);
    chk("stall1_cw4", stall1_4, m_st4_1);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + i * 32'h0001_0101;
    mem[5] = 32'h2402_000A;
    model_reset();

    // Reset held with both ports requesting.
    rst = 1'b1; req0 = 1'b1; req1 = 1'b1; addr0 = 6'd3; addr1 = 6'd7;
    cycle();
    cycle();
    rst = 1'b0;

    // Contention from reset: 0,1,0,1.
    repeat (4) cycle();
    chk("stall0_contention", stall0, 32'd2);
    chk("stall1_contention", stall1, 32'd2);

    // Idle: data held, stalls unchanged.
    req0 = 1'b0; req1 = 1'b0;
    repeat (5) cycle();
    chk("rdata0_idle_hold", rdata0, mem[3]);
    chk("rdata1_idle_hold", rdata1, mem[7]);

    // Single port streaming.
    req0 = 1'b1; addr0 = 6'd5;
    repeat (3) cycle();
    req0 = 1'b0;
    cycle();
    chk("rdata0_single", rdata0, 32'h2402_000A);
    chk("stall0_single", stall0, 32'd2);

    // Pointer memory: port 1 alone, then contention goes to port 0.
    req1 = 1'b1; addr1 = 6'd9;
    cycle();
    req0 = 1'b1; addr0 = 6'd11;
    cycle();
    chk("rdata0_ptr", rdata0, mem[11]);
    req0 = 1'b0; req1 = 1'b0;
    cycle();

    // Asynchronous reset inside a granted cycle.
    req0 = 1'b1; addr0 = 6'd13;
    @(negedge clk);
    chk("gnt0_pre_rst", gnt0, 1'b1);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("gnt0_in_rst", gnt0, 1'b0);
    chk("stall1_async_clr", stall1, 32'd0);
    @(posedge clk);
    #1;
    chk("rvalid0_after_rst", rvalid0, 1'b0);
    chk("rdata0_after_rst", rdata0, 32'd0);
    rst = 1'b0;

    // Post-reset contention again starts with port 0.
    req1 = 1'b1; addr0 = 6'd3; addr1 = 6'd7;
    repeat (2) cycle();

    // Long contention: the 4-bit counters saturate and do not wrap.
    repeat (40) cycle();
    chk("stall1_cw4_sat", stall1_4, 32'd15);
    chk("stall0_cw4_sat", stall0_4, 32'd15);
    chk("stall1_wide", stall1, 32'd21);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
